accum_feeder: RTL and testbench

//   Transmit side of the putFlag/value byte-burst interface that the Accumulator receives.

---
 rtl/accum_feeder.sv | 131 +++++++++++++
 tb/tb_accum_feeder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/accum_feeder.sv
// Transmit side of the putFlag/value byte-burst link: captures up to three bytes on load,
// replays the valid ones as one contiguous burst, then holds an idle gap before the next load.
module accum_feeder #(
    parameter int WIDTH      = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             in0_valid,
    input  logic             in1_valid,
    input  logic             in2_valid,
    output logic             busy,
    output logic             putFlag,
    output logic [WIDTH-1:0] value,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    // GAP state covers every gap cycle except the last, which is already spent in IDLE with busy low.
    localparam logic [3:0] GAP_RELOAD = (GAP_CYCLES >= 2) ? 4'(GAP_CYCLES - 2) : 4'd0;

    state_t           state_q;
    logic [WIDTH-1:0] slot_q [3];
    logic [2:0]       rem_q;
    logic [3:0]       gap_cnt_q;
    logic             busy_q;
    logic             put_q;
    logic [WIDTH-1:0] value_q;
    logic             done_q;

    logic [WIDTH-1:0] in_w [3];
    logic [2:0]       pick_mask;
    logic [1:0]       pick_idx;
    logic             pick_any;
    logic [WIDTH-1:0] pick_val;
    logic [2:0]       rem_d;

    assign in_w[0] = in0;
    assign in_w[1] = in1;
    assign in_w[2] = in2;

    // In IDLE the first byte comes straight from the inputs so putFlag rises right after the load edge.
    always_comb begin
        pick_mask = (state_q == IDLE) ? {in2_valid, in1_valid, in0_valid} : rem_q;
        pick_idx  = 2'd0;
        for (int i = 2; i >= 0; i--) begin
            if (pick_mask[i]) begin
                pick_idx = 2'(i);
            end
        end
        pick_any = |pick_mask;
        pick_val = (state_q == IDLE) ? in_w[pick_idx] : slot_q[pick_idx];
        rem_d    = pick_mask & ~(3'b001 << pick_idx);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            rem_q     <= '0;
            gap_cnt_q <= '0;
            busy_q    <= 1'b0;
            put_q     <= 1'b0;
            value_q   <= '0;
            done_q    <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (load) begin
                        for (int i = 0; i < 3; i++) begin
                            slot_q[i] <= in_w[i];
                        end
                        rem_q <= rem_d;
                        if (pick_any) begin
                            state_q <= SEND;
                            busy_q  <= 1'b1;
                            put_q   <= 1'b1;
                            value_q <= pick_val;
                        end else begin
                            done_q    <= 1'b1;
                            gap_cnt_q <= GAP_RELOAD;
                            state_q   <= (GAP_CYCLES == 1) ? IDLE : GAP;
                            busy_q    <= (GAP_CYCLES != 1);
                        end
                    end
                end
                SEND: begin
                    if (pick_any) begin
                        value_q <= pick_val;
                        rem_q   <= rem_d;
                    end else begin
                        put_q     <= 1'b0;
                        value_q   <= '0;
                        done_q    <= 1'b1;
                        gap_cnt_q <= GAP_RELOAD;
                        state_q   <= (GAP_CYCLES == 1) ? IDLE : GAP;
                        busy_q    <= (GAP_CYCLES != 1);
                    end
                end
                GAP: begin
                    if (gap_cnt_q == 4'd0) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    put_q   <= 1'b0;
                    value_q <= '0;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign putFlag = put_q;
    assign value   = value_q;
    assign done    = done_q;

endmodule

// File: tb/tb_accum_feeder.sv
// Directed bench for accum_feeder: each task loads a vector and checks the
// per-cycle {busy, putFlag, done, value} trace against hand-derived expectations.
module tb_accum_feeder;

    logic       clk = 1'b0;
    logic       reset;
    logic       load;
    logic [7:0] in0, in1, in2;
    logic       in0_valid, in1_valid, in2_valid;
    logic       busy, putFlag, done;
    logic [7:0] value;

    int checks   = 0;
    int failures = 0;

    accum_feeder #(.WIDTH(8), .GAP_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .load(load),
        .in0(in0), .in1(in1), .in2(in2),
        .in0_valid(in0_valid), .in1_valid(in1_valid), .in2_valid(in2_valid),
        .busy(busy), .putFlag(putFlag), .value(value), .done(done)
    );

    always #5 clk = ~clk;

    // Packed view {busy, putFlag, done, value}
    function automatic logic [10:0] pk(input logic b, input logic p, input logic d, input logic [7:0] v);
        return {b, p, d, v};
    endfunction

    function automatic logic [10:0] obs();
        return {busy, putFlag, done, value};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2, input logic [2:0] v);
        in0 = d0; in1 = d1; in2 = d2;
        {in2_valid, in1_valid, in0_valid} = v;
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        do_load(8'd9, 8'd9, 8'd9, 3'b111);
        checks++;
        if (obs() !== pk(0, 0, 0, 8'd0)) begin
            failures++;
            $display("FAIL reset_with_load got=%h want=%h", obs(), pk(0, 0, 0, 8'd0));
        end
        reset = 1'b0;
        step();
        checks++;
        if (obs() !== pk(0, 0, 0, 8'd0)) begin
            failures++;
            $display("FAIL reset_release got=%h want=%h", obs(), pk(0, 0, 0, 8'd0));
        end
    endtask

    task automatic test_single();
        logic [10:0] exp [4];
        exp = '{pk(1, 1, 0, 8'd10), pk(1, 0, 1, 8'd0), pk(0, 0, 0, 8'd0), pk(0, 0, 0, 8'd0)};
        do_load(8'd10, 8'd0, 8'd0, 3'b001);
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (obs() !== exp[c]) begin
                failures++;
                $display("FAIL t1_single cycle=%0d got=%h want=%h", c, obs(), exp[c]);
            end
            step();
        end
    endtask

    task automatic test_two_slots();
        logic [10:0] exp [4];
        exp = '{pk(1, 1, 0, 8'd20), pk(1, 1, 0, 8'd30), pk(1, 0, 1, 8'd0), pk(0, 0, 0, 8'd0)};
        do_load(8'd20, 8'd30, 8'd40, 3'b011);
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (obs() !== exp[c]) begin
                failures++;
                $display("FAIL t2_two_slots cycle=%0d got=%h want=%h", c, obs(), exp[c]);
            end
            step();
        end
    endtask

    task automatic test_skip_slot();
        logic [10:0] exp [4];
        exp = '{pk(1, 1, 0, 8'd40), pk(1, 1, 0, 8'd60), pk(1, 0, 1, 8'd0), pk(0, 0, 0, 8'd0)};
        do_load(8'd40, 8'd50, 8'd60, 3'b101);
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (obs() !== exp[c]) begin
                failures++;
                $display("FAIL t3_skip_slot cycle=%0d got=%h want=%h", c, obs(), exp[c]);
            end
            if (c == 0) begin
                in2 = 8'd99;
                in1_valid = 1'b1;
            end
            step();
        end
    endtask

    task automatic test_load_while_busy();
        logic [10:0] exp [6];
        exp = '{pk(1, 1, 0, 8'd40), pk(1, 1, 0, 8'd50), pk(1, 1, 0, 8'd60),
                pk(1, 0, 1, 8'd0), pk(0, 0, 0, 8'd0), pk(0, 0, 0, 8'd0)};
        do_load(8'd40, 8'd50, 8'd60, 3'b111);
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (obs() !== exp[c]) begin
                failures++;
                $display("FAIL t4_load_busy cycle=%0d got=%h want=%h", c, obs(), exp[c]);
            end
            if (c == 0) begin
                in0 = 8'd1; in1 = 8'd2; in2 = 8'd3;
                load = 1'b1;
            end else if (c == 1) begin
                load = 1'b0;
            end
            step();
        end
    endtask

    task automatic test_load_at_busy_fall();
        logic [10:0] exp [4];
        exp = '{pk(1, 1, 0, 8'd10), pk(1, 0, 1, 8'd0), pk(0, 0, 0, 8'd0), pk(0, 0, 0, 8'd0)};
        do_load(8'd10, 8'd0, 8'd0, 3'b001);
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (obs() !== exp[c]) begin
                failures++;
                $display("FAIL busy_fall_load cycle=%0d got=%h want=%h", c, obs(), exp[c]);
            end
            if (c == 1) begin
                in0 = 8'd99;
                load = 1'b1;
            end else if (c == 2) begin
                load = 1'b0;
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        do_load(8'd5, 8'd0, 8'd0, 3'b001);
        step();
        step();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_busy_low got=%b want=0", busy);
        end
        do_load(8'd0, 8'd6, 8'd0, 3'b010);
        checks++;
        if (obs() !== pk(1, 1, 0, 8'd6)) begin
            failures++;
            $display("FAIL b2b_second_load got=%h want=%h", obs(), pk(1, 1, 0, 8'd6));
        end
        step();
        step();
    endtask

    task automatic test_empty();
        logic [10:0] exp [3];
        exp = '{pk(1, 0, 1, 8'd0), pk(0, 0, 0, 8'd0), pk(0, 0, 0, 8'd0)};
        do_load(8'd11, 8'd12, 8'd13, 3'b000);
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (obs() !== exp[c]) begin
                failures++;
                $display("FAIL t5_empty cycle=%0d got=%h want=%h", c, obs(), exp[c]);
            end
            step();
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [10:0] exp [4];
        do_load(8'd40, 8'd50, 8'd60, 3'b111);
        step();
        checks++;
        if (obs() !== pk(1, 1, 0, 8'd50)) begin
            failures++;
            $display("FAIL t6_pre_reset got=%h want=%h", obs(), pk(1, 1, 0, 8'd50));
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (obs() !== pk(0, 0, 0, 8'd0)) begin
            failures++;
            $display("FAIL t6_truncated got=%h want=%h", obs(), pk(0, 0, 0, 8'd0));
        end
        step();
        checks++;
        if (obs() !== pk(0, 0, 0, 8'd0)) begin
            failures++;
            $display("FAIL t6_no_done got=%h want=%h", obs(), pk(0, 0, 0, 8'd0));
        end
        exp = '{pk(1, 1, 0, 8'd7), pk(1, 0, 1, 8'd0), pk(0, 0, 0, 8'd0), pk(0, 0, 0, 8'd0)};
        do_load(8'd7, 8'd0, 8'd0, 3'b001);
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (obs() !== exp[c]) begin
                failures++;
                $display("FAIL t6_fresh_load cycle=%0d got=%h want=%h", c, obs(), exp[c]);
            end
            step();
        end
    endtask

    initial begin
        reset = 1'b1;
        load = 1'b0;
        in0 = '0; in1 = '0; in2 = '0;
        in0_valid = 1'b0; in1_valid = 1'b0; in2_valid = 1'b0;
        step();
        step();
        test_reset();
        test_single();
        test_two_slots();
        test_skip_slot();
        test_load_while_busy();
        test_load_at_busy_fall();
        test_back_to_back();
        test_empty();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
